// File: rtl/ifu_pkg.sv
// Shared fetch-stage types and constants, also used by decode and hazard logic.
package ifu_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory, hazard/branch controls, IF/ID outputs and counters.
interface instruction_fetch_unit_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    input  stall, redirect, redirect_target, imem_instr,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, halted,
           fetch_count, stall_count
  );

  modport slave (
    output stall, redirect, redirect_target, imem_instr,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, halted,
           fetch_count, stall_count
  );

endinterface

// File: rtl/pc_register.sv
// Program counter: 32-bit register with load enable and async active-low reset.
module pc_register #(
  parameter logic [31:0] ResetValue = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= ResetValue;
    end else if (load_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, IF/ID register, redirect/stall/halt FSM.
// Optional performance counters are enabled with FETCH_COUNTERS_EN.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter logic [31:0] NOP_WORD  = ifu_pkg::NOP_WORD
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  instruction_fetch_unit_if.master bus
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        pc_load;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  pc_register #(
    .ResetValue (word_align(RESET_PC))
  ) u_pc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (pc_load),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun, StHalted: begin
        if (bus.redirect) begin
          pc_load = 1'b1;
          pc_d    = word_align(bus.redirect_target);
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
          state_d = StRun;
        end else if (bus.stall) begin
          // Hold everything.
        end else if (state_q == StRun) begin
          instr_d = bus.imem_instr;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (bus.imem_instr == HALT_WORD) begin
            state_d = StHalted;
          end else begin
            pc_load = 1'b1;
            pc_d    = pc_plus4;
          end
        end else begin
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StBoot;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.halted         = (state_q == StHalted);

`ifdef FETCH_COUNTERS_EN
  logic        fetch_inc, stall_inc;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign fetch_inc = (state_q == StRun) && !bus.redirect && !bus.stall;
  assign stall_inc = (state_q != StBoot) && !bus.redirect && bus.stall;

  // Saturating increments.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.fetch_count = 32'd0;
  assign bus.stall_count = 32'd0;
`endif

endmodule
